sc_axil2regbus: RTL and testbench

AXI4-Lite slave that converts CPU/interconnect transactions into SC register-bus cycles (wadr/wenb/wdat, radr/renb/rdat) for register blocks built on screg_pkg.
It sits directly upstream of those blocks and is their only bus master.
Write and read channels are independent; each can have one transaction outstanding.
It honours the register-side wait (wwat/rwat) and error (werr/rerr) returns.

---
 rtl/sc_axil2regbus_pkg.sv | 20 ++
 rtl/sc_axil2regbus_if.sv | 36 +++
 rtl/sc_axil2regbus_wdog.sv | 33 +++
 rtl/sc_axil2regbus.sv | 191 +++++++++++++++++++
 tb/tb_sc_axil2regbus.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_axil2regbus_pkg.sv
// Shared types and helpers for the AXI4-Lite to SC register-bus bridge
// (the screg_pkg additions used by sc_axil2regbus).
//   SC_RESP_OKAY / SC_RESP_SLVERR : AXI response codes driven on BRESP/RRESP
//   sc_axil_wstate_t              : write FSM states
//   sc_axil_rstate_t              : read FSM states
//   mk_typ(prot)                  : builds the 10-bit regbus type field from AxPROT
package sc_axil2regbus_pkg;

   localparam logic [1:0] SC_RESP_OKAY   = 2'b00;
   localparam logic [1:0] SC_RESP_SLVERR = 2'b10;

   // Write and read states share a package, so the literals carry a prefix.
   typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_ISSUE, W_RESP} sc_axil_wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RESP} sc_axil_rstate_t;

   function automatic logic [9:0] mk_typ(input logic [2:0] prot);
      return {7'b0, prot};
   endfunction

endpackage

// File: rtl/sc_axil2regbus_if.sv
// AXI4-Lite bus bundle for sc_axil2regbus.
//   modport slave  : bridge side (accepts AW/W/AR, returns B/R)
//   modport master : CPU / interconnect side
interface sc_axil2regbus_if;
   logic [31:0] AWADDR;
   logic [2:0]  AWPROT;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [31:0] ARADDR;
   logic [2:0]  ARPROT;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/sc_axil2regbus_wdog.sv
// Register-bus wait watchdog, built only when SC_REGBUS_TIMEOUT_EN is defined.
//   clk, rst_b : clock, synchronous active-low reset
//   start      : held high while not issuing; clears the count
//   waiting    : issuing and the register side is asserting wait
//   expire     : wait has lasted TIMEOUT_CYCLES cycles; force completion
// The counter saturates at TIMEOUT_CYCLES.
`ifdef SC_REGBUS_TIMEOUT_EN
module sc_regbus_wdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_b,
   input  logic start,
   input  logic waiting,
   output logic expire
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_b)
         cnt <= '0;
      else if (start)
         cnt <= '0;
      else if (waiting && cnt != TC)
         cnt <= cnt + CW'(1);
   end

   assign expire = waiting && (cnt == TC);
endmodule
`endif

// File: rtl/sc_axil2regbus.sv
// AXI4-Lite slave that turns CPU transactions into SC register-bus cycles.
// Independent write and read FSMs, one outstanding transaction per direction.
// Optional macro SC_REGBUS_TIMEOUT_EN adds a wait watchdog per direction that
// forces an error completion after TIMEOUT_CYCLES wait cycles.
// Ports:
//   ACLK, ARESETN            : clock, synchronous active-low reset
//   axi                      : AXI4-Lite slave bundle (AW/W/B/AR/R)
//   wadr/wtyp/wenb/wdat      : regbus write request (wenb nonzero only while issuing)
//   wwat/werr                : regbus write wait / error
//   radr/rtyp/renb           : regbus read request
//   rdat/rwat/rerr           : regbus read data / wait / error
//
//   write state | meaning
//   W_IDLE      | AWREADY=WREADY=1, waiting for AW and/or W
//   W_ADDR      | AW held, waiting for W
//   W_DATA      | W held, waiting for AW
//   W_ISSUE     | regbus write driven, held while wwat
//   W_RESP      | BVALID held until BREADY
//
//   read state  | meaning
//   R_IDLE      | ARREADY=1, waiting for AR
//   R_ISSUE     | regbus read driven, held while rwat
//   R_RESP      | RVALID held until RREADY
module sc_axil2regbus
   import sc_axil2regbus_pkg::*;
#(
   parameter logic [31:0] ADDR_MASK      = 32'hFFFF_FFFF,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                ACLK,
   input  logic                ARESETN,
   sc_axil2regbus_if.slave     axi,
   output logic [31:0]         wadr,
   output logic [9:0]          wtyp,
   output logic [3:0]          wenb,
   output logic [31:0]         wdat,
   input  logic                wwat,
   input  logic                werr,
   output logic [31:0]         radr,
   output logic [9:0]          rtyp,
   output logic                renb,
   input  logic [31:0]         rdat,
   input  logic                rwat,
   input  logic                rerr
);
   sc_axil_wstate_t wstate;
   sc_axil_rstate_t rstate;
   logic [3:0]      w_strb;
   logic            w_expire;
   logic            r_expire;

   wire aw_hs = axi.AWVALID && axi.AWREADY;
   wire w_hs  = axi.WVALID && axi.WREADY;
   wire ar_hs = axi.ARVALID && axi.ARREADY;

`ifdef SC_REGBUS_TIMEOUT_EN
   sc_regbus_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog_w (
      .clk(ACLK), .rst_b(ARESETN), .start(wstate != W_ISSUE),
      .waiting((wstate == W_ISSUE) && wwat), .expire(w_expire)
   );
   sc_regbus_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog_r (
      .clk(ACLK), .rst_b(ARESETN), .start(rstate != R_ISSUE),
      .waiting((rstate == R_ISSUE) && rwat), .expire(r_expire)
   );
`else
   assign w_expire = 1'b0;
   assign r_expire = 1'b0;
`endif

   // Address/type are loaded on AW acceptance and data on W acceptance; wenb
   // stays 0 until both are present, so the early load is invisible to slaves.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         wstate      <= W_IDLE;
         axi.AWREADY <= 1'b0;
         axi.WREADY  <= 1'b0;
         axi.BVALID  <= 1'b0;
         axi.BRESP   <= SC_RESP_OKAY;
         wadr        <= '0;
         wtyp        <= '0;
         wdat        <= '0;
         wenb        <= '0;
         w_strb      <= '0;
      end else begin
         if (aw_hs) begin
            wadr <= axi.AWADDR & ADDR_MASK;
            wtyp <= mk_typ(axi.AWPROT);
         end
         if (w_hs) begin
            wdat   <= axi.WDATA;
            w_strb <= axi.WSTRB;
         end
         case (wstate)
            W_IDLE: begin
               if (aw_hs && w_hs) begin
                  wstate      <= W_ISSUE;
                  wenb        <= axi.WSTRB;
                  axi.AWREADY <= 1'b0;
                  axi.WREADY  <= 1'b0;
               end else if (aw_hs) begin
                  wstate      <= W_ADDR;
                  axi.AWREADY <= 1'b0;
                  axi.WREADY  <= 1'b1;
               end else if (w_hs) begin
                  wstate      <= W_DATA;
                  axi.AWREADY <= 1'b1;
                  axi.WREADY  <= 1'b0;
               end else begin
                  axi.AWREADY <= 1'b1;
                  axi.WREADY  <= 1'b1;
               end
            end
            W_ADDR: begin
               if (w_hs) begin
                  wstate     <= W_ISSUE;
                  wenb       <= axi.WSTRB;
                  axi.WREADY <= 1'b0;
               end
            end
            W_DATA: begin
               if (aw_hs) begin
                  wstate      <= W_ISSUE;
                  wenb        <= w_strb;
                  axi.AWREADY <= 1'b0;
               end
            end
            W_ISSUE: begin
               if (!wwat || w_expire) begin
                  // Still waiting here means the watchdog fired.
                  wstate     <= W_RESP;
                  wenb       <= '0;
                  axi.BVALID <= 1'b1;
                  axi.BRESP  <= (wwat || werr) ? SC_RESP_SLVERR : SC_RESP_OKAY;
               end
            end
            W_RESP: begin
               if (axi.BREADY) begin
                  wstate      <= W_IDLE;
                  axi.BVALID  <= 1'b0;
                  axi.AWREADY <= 1'b1;
                  axi.WREADY  <= 1'b1;
               end
            end
            default: wstate <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         rstate      <= R_IDLE;
         axi.ARREADY <= 1'b0;
         axi.RVALID  <= 1'b0;
         axi.RRESP   <= SC_RESP_OKAY;
         axi.RDATA   <= '0;
         radr        <= '0;
         rtyp        <= '0;
         renb        <= 1'b0;
      end else begin
         case (rstate)
            R_IDLE: begin
               axi.ARREADY <= 1'b1;
               if (ar_hs) begin
                  rstate      <= R_ISSUE;
                  radr        <= axi.ARADDR & ADDR_MASK;
                  rtyp        <= mk_typ(axi.ARPROT);
                  renb        <= 1'b1;
                  axi.ARREADY <= 1'b0;
               end
            end
            R_ISSUE: begin
               if (!rwat || r_expire) begin
                  rstate     <= R_RESP;
                  renb       <= 1'b0;
                  axi.RVALID <= 1'b1;
                  axi.RDATA  <= rwat ? 32'h0 : rdat;
                  axi.RRESP  <= (rwat || rerr) ? SC_RESP_SLVERR : SC_RESP_OKAY;
               end
            end
            R_RESP: begin
               if (axi.RREADY) begin
                  rstate      <= R_IDLE;
                  axi.RVALID  <= 1'b0;
                  axi.ARREADY <= 1'b1;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sc_axil2regbus.sv
module tb_sc_axil2regbus;
   logic        ACLK;
   logic        ARESETN;
   logic [31:0] wadr;
   logic [9:0]  wtyp;
   logic [3:0]  wenb;
   logic [31:0] wdat;
   logic        wwat;
   logic        werr;
   logic [31:0] radr;
   logic [9:0]  rtyp;
   logic        renb;
   logic [31:0] rdat;
   logic        rwat;
   logic        rerr;

   sc_axil2regbus_if axi();

   sc_axil2regbus #(.ADDR_MASK(32'hFFFF_FFFF), .TIMEOUT_CYCLES(8)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .axi(axi),
      .wadr(wadr), .wtyp(wtyp), .wenb(wenb), .wdat(wdat), .wwat(wwat), .werr(werr),
      .radr(radr), .rtyp(rtyp), .renb(renb), .rdat(rdat), .rwat(rwat), .rerr(rerr)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [31:0] adr;
      logic [9:0]  typ;
      logic [31:0] dat;
      logic [3:0]  enb;
   } wexp_t;
   typedef struct {
      logic [31:0] adr;
      logic [9:0]  typ;
   } arexp_t;
   typedef struct {
      logic [31:0] dat;
      logic [1:0]  resp;
   } rexp_t;

   wexp_t      exp_w[$];
   arexp_t     exp_ar[$];
   rexp_t      exp_r[$];
   logic [1:0] exp_b[$];

   int tests = 0;
   int fails = 0;

   wexp_t      mw;
   arexp_t     mar;
   rexp_t      mr;
   logic [1:0] mb;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got an output with no expected entry at %0t", name, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge ACLK);
      #1;
   endtask

   // Scoreboard monitor: compares whenever the DUT presents a response or
   // completes a regbus cycle.
   always @(negedge ACLK) begin
      if (ARESETN) begin
         if (axi.BVALID && axi.BREADY) begin
            if (exp_b.size() == 0) unexpected("b_resp");
            else begin
               mb = exp_b.pop_front();
               check("bresp", axi.BRESP, mb);
            end
         end
         if (axi.RVALID && axi.RREADY) begin
            if (exp_r.size() == 0) unexpected("r_resp");
            else begin
               mr = exp_r.pop_front();
               check("rdata", axi.RDATA, mr.dat);
               check("rresp", axi.RRESP, mr.resp);
            end
         end
         if (wenb != 4'h0 && !wwat) begin
            if (exp_w.size() == 0) unexpected("regbus_write");
            else begin
               mw = exp_w.pop_front();
               check("wadr", wadr, mw.adr);
               check("wtyp", wtyp, mw.typ);
               check("wdat", wdat, mw.dat);
               check("wenb", wenb, mw.enb);
            end
         end
         if (renb && !rwat) begin
            if (exp_ar.size() == 0) unexpected("regbus_read");
            else begin
               mar = exp_ar.pop_front();
               check("radr", radr, mar.adr);
               check("rtyp", rtyp, mar.typ);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no end of run expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      ARESETN = 1'b0;
      axi.AWADDR = '0; axi.AWPROT = '0; axi.AWVALID = 1'b0;
      axi.WDATA = '0; axi.WSTRB = '0; axi.WVALID = 1'b0; axi.BREADY = 1'b1;
      axi.ARADDR = '0; axi.ARPROT = '0; axi.ARVALID = 1'b0; axi.RREADY = 1'b1;
      wwat = 1'b0; werr = 1'b0; rwat = 1'b0; rerr = 1'b0; rdat = '0;

      // Reset state
      tick(2);
      check("rst_awready", axi.AWREADY, 0);
      check("rst_wready", axi.WREADY, 0);
      check("rst_arready", axi.ARREADY, 0);
      check("rst_bvalid", axi.BVALID, 0);
      check("rst_rvalid", axi.RVALID, 0);
      check("rst_wenb", wenb, 0);
      check("rst_renb", renb, 0);
      check("rst_wadr", wadr, 0);
      check("rst_rdata", axi.RDATA, 0);
      ARESETN = 1'b1;
      tick(1);
      check("post_rst_awready", axi.AWREADY, 1);
      check("post_rst_arready", axi.ARREADY, 1);

      // 1: AW and W in the same cycle, no wait
      axi.AWADDR = 32'h10; axi.AWPROT = 3'b010; axi.AWVALID = 1'b1;
      axi.WDATA = 32'hDEADBEEF; axi.WSTRB = 4'hF; axi.WVALID = 1'b1;
      exp_w.push_back('{32'h10, 10'h002, 32'hDEADBEEF, 4'hF});
      exp_b.push_back(2'b00);
      tick(1);
      axi.AWVALID = 1'b0; axi.WVALID = 1'b0;
      check("t1_issue_wenb", wenb, 4'hF);
      check("t1_bvalid_c1", axi.BVALID, 0);
      tick(1);
      check("t1_bvalid_c2", axi.BVALID, 1);
      check("t1_wenb_after", wenb, 0);
      tick(1);
      check("t1_bvalid_done", axi.BVALID, 0);
      tick(1);

      // 2: W before AW, partial strobe, 3 wait cycles, error reply
      wwat = 1'b1;
      axi.WDATA = 32'hA5A50F0F; axi.WSTRB = 4'b0101; axi.WVALID = 1'b1;
      tick(1);
      axi.WVALID = 1'b0;
      check("t2_wready_held", axi.WREADY, 0);
      check("t2_awready_open", axi.AWREADY, 1);
      axi.AWADDR = 32'h20; axi.AWPROT = 3'b000; axi.AWVALID = 1'b1;
      exp_w.push_back('{32'h20, 10'h000, 32'hA5A50F0F, 4'b0101});
      exp_b.push_back(2'b10);
      tick(1);
      axi.AWVALID = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t2_hold_wenb", wenb, 4'b0101);
         check("t2_hold_wadr", wadr, 32'h20);
         check("t2_hold_wdat", wdat, 32'hA5A50F0F);
         check("t2_hold_bvalid", axi.BVALID, 0);
         tick(1);
      end
      wwat = 1'b0; werr = 1'b1;
      check("t2_last_wenb", wenb, 4'b0101);
      tick(1);
      werr = 1'b0;
      check("t2_bvalid", axi.BVALID, 1);
      check("t2_wenb_after", wenb, 0);
      tick(1);
      check("t2_bvalid_done", axi.BVALID, 0);
      check("t2_wenb_idle", wenb, 0);
      tick(1);

      // 3: WSTRB=0 still completes with OKAY and no enables
      axi.AWADDR = 32'h50; axi.AWPROT = 3'b001; axi.AWVALID = 1'b1;
      axi.WDATA = 32'h0BADF00D; axi.WSTRB = 4'h0; axi.WVALID = 1'b1;
      exp_b.push_back(2'b00);
      tick(1);
      axi.AWVALID = 1'b0; axi.WVALID = 1'b0;
      check("t3_issue_wenb", wenb, 0);
      check("t3_issue_wadr", wadr, 32'h50);
      tick(1);
      check("t3_bvalid", axi.BVALID, 1);
      tick(2);

      // 4: read with 2 wait cycles, error, response held while RREADY=0
      axi.RREADY = 1'b0; rwat = 1'b1;
      axi.ARADDR = 32'h24; axi.ARPROT = 3'b101; axi.ARVALID = 1'b1;
      exp_ar.push_back('{32'h24, 10'h005});
      exp_r.push_back('{32'h12345678, 2'b10});
      tick(1);
      axi.ARVALID = 1'b0;
      check("t4_renb", renb, 1);
      check("t4_radr", radr, 32'h24);
      check("t4_arready", axi.ARREADY, 0);
      tick(2);
      check("t4_renb_held", renb, 1);
      check("t4_rvalid_wait", axi.RVALID, 0);
      rwat = 1'b0; rdat = 32'h12345678; rerr = 1'b1;
      tick(1);
      rdat = 32'h0; rerr = 1'b0;
      check("t4_renb_after", renb, 0);
      for (int i = 0; i < 5; i++) begin
         check("t4_rvalid_hold", axi.RVALID, 1);
         check("t4_rdata_hold", axi.RDATA, 32'h12345678);
         check("t4_rresp_hold", axi.RRESP, 2'b10);
         tick(1);
      end
      axi.RREADY = 1'b1;
      tick(1);
      check("t4_rvalid_done", axi.RVALID, 0);
      tick(1);

      // 5: concurrent write and read
      axi.RREADY = 1'b0; rdat = 32'hCAFEF00D;
      axi.AWADDR = 32'h00; axi.AWPROT = 3'b000; axi.AWVALID = 1'b1;
      axi.WDATA = 32'h11112222; axi.WSTRB = 4'hF; axi.WVALID = 1'b1;
      axi.ARADDR = 32'h04; axi.ARPROT = 3'b000; axi.ARVALID = 1'b1;
      exp_w.push_back('{32'h00, 10'h000, 32'h11112222, 4'hF});
      exp_b.push_back(2'b00);
      exp_ar.push_back('{32'h04, 10'h000});
      exp_r.push_back('{32'hCAFEF00D, 2'b00});
      tick(1);
      axi.AWVALID = 1'b0; axi.WVALID = 1'b0; axi.ARVALID = 1'b0;
      check("t5_overlap_wenb", wenb, 4'hF);
      check("t5_overlap_renb", renb, 1);
      tick(1);
      check("t5_bvalid", axi.BVALID, 1);
      check("t5_rvalid", axi.RVALID, 1);
      check("t5_arready_low", axi.ARREADY, 0);
      tick(1);
      check("t5_arready_still_low", axi.ARREADY, 0);
      check("t5_rvalid_held", axi.RVALID, 1);
      axi.RREADY = 1'b1;
      tick(1);
      check("t5_arready_back", axi.ARREADY, 1);
      check("t5_rvalid_done", axi.RVALID, 0);
      tick(1);

      // 6: reset during write ISSUE with wwat=1
      wwat = 1'b1;
      axi.AWADDR = 32'h30; axi.AWVALID = 1'b1;
      axi.WDATA = 32'h33334444; axi.WSTRB = 4'h3; axi.WVALID = 1'b1;
      tick(1);
      axi.AWVALID = 1'b0; axi.WVALID = 1'b0;
      check("t6_issue_wenb", wenb, 4'h3);
      tick(1);
      ARESETN = 1'b0;
      tick(1);
      check("t6_rst_wenb", wenb, 0);
      check("t6_rst_bvalid", axi.BVALID, 0);
      check("t6_rst_awready", axi.AWREADY, 0);
      check("t6_rst_wready", axi.WREADY, 0);
      tick(1);
      ARESETN = 1'b1; wwat = 1'b0;
      tick(1);
      check("t6_awready", axi.AWREADY, 1);
      check("t6_wready", axi.WREADY, 1);
      tick(3);
      check("t6_no_bvalid", axi.BVALID, 0);

      // 7: read with rwat stuck high
      rwat = 1'b1; rdat = 32'hFFFFFFFF;
      axi.ARADDR = 32'h40; axi.ARVALID = 1'b1;
`ifdef SC_REGBUS_TIMEOUT_EN
      exp_r.push_back('{32'h0, 2'b10});
`endif
      tick(1);
      axi.ARVALID = 1'b0;
      n = 0;
      while (!axi.RVALID && n < 1000) begin
         tick(1);
         n++;
      end
`ifdef SC_REGBUS_TIMEOUT_EN
      check("t7_timeout_latency", n, 9);
      tick(1);
`else
      check("t7_no_response", axi.RVALID, 0);
`endif
      rwat = 1'b0;
      ARESETN = 1'b0;
      tick(2);
      ARESETN = 1'b1;
      tick(2);

      check("q_w_empty", exp_w.size(), 0);
      check("q_b_empty", exp_b.size(), 0);
      check("q_ar_empty", exp_ar.size(), 0);
      check("q_r_empty", exp_r.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
